// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: accepts a pair of packed signed vectors and steps one
// shared multiply-accumulate through the N element pairs, one pair per clock,
// then holds the signed sum on a valid/ready result port until it is taken.
module dot_product_sequencer #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int AW = 2*W + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       a_in,
  input  logic [N*W-1:0]       b_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [AW-1:0] result,
  output logic                 busy
);

  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [N*W-1:0]        a_p0;
  logic [N*W-1:0]        b_p0;
  logic signed [AW-1:0]  acc;
  logic signed [W-1:0]   a_el;
  logic signed [W-1:0]   b_el;
  logic signed [2*W-1:0] prod;

  // Widen a full-precision product to accumulator width; AW always leaves
  // headroom above 2W, so the sum can never overflow.
  function automatic logic signed [AW-1:0] sext_prod(input logic signed [2*W-1:0] p);
    return {{(AW-2*W){p[2*W-1]}}, p};
  endfunction

  // Capture operands on the accept edge only; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p0 <= a_in;
      b_p0 <= b_in;
    end
  end

  // Select the current element pair and form its signed 2W-bit product.
  always_comb begin
    a_el = a_p0[idx*W +: W];
    b_el = b_p0[idx*W +: W];
    prod = a_el * b_el;
  end

  // Sequencer: accept, accumulate one element per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + sext_prod(prod);
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = acc;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: table-driven directed vectors,
// randomized operations against a plain-arithmetic dot-product model, and
// hand-written sequences for backpressure, mid-operation reset and back-to-back.
module tb_dot_product_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 2*W + $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*W-1:0]       a_in;
  logic [N*W-1:0]       b_in;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [AW-1:0] result;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(.N(N), .W(W), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    longint         exp;
    string          name;
  } vec_t;

  // Reference: sum of signed element products in plain integer arithmetic.
  function automatic longint model(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    longint s;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    s = 0;
    for (int i = 0; i < N; i++) begin
      x = a[i*W +: W];
      y = b[i*W +: W];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] vec4(input int e0, input int e1, input int e2, input int e3);
    logic [N*W-1:0] v;
    v[0*W +: W] = e0[W-1:0];
    v[1*W +: W] = e1[W-1:0];
    v[2*W +: W] = e2[W-1:0];
    v[3*W +: W] = e3[W-1:0];
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: accept, scramble inputs during MAC, check
  // latency and sum, hold res_ready low for `hold` cycles, then hand off.
  task automatic run_op(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input longint exp, input int hold, input bit pulse_valid,
                        input string name);
    int cyc;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({name, " in_ready before accept"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    res_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      a_in = $urandom;
      b_in = $urandom;
      tick();
      cyc++;
    end
    check({name, " latency"}, cyc, N + 1);
    check({name, " result"}, longint'(result), exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse_valid ? ((i % 2) == 0) : 1'b0;
      a_in = $urandom;
      b_in = $urandom;
      tick();
      check({name, " held res_valid"}, longint'(res_valid), 1);
      check({name, " held result"}, longint'(result), exp);
      check({name, " held in_ready"}, longint'(in_ready), 0);
      check({name, " held busy"}, longint'(busy), 1);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, " res_valid after handoff"}, longint'(res_valid), 0);
    check({name, " in_ready after handoff"}, longint'(in_ready), 1);
  endtask

  vec_t   vecs[4];
  longint got_res[$];
  int     got_cyc[$];
  logic [N*W-1:0] pa[3];
  logic [N*W-1:0] pb[3];

  initial begin
    int k;
    int cyc;
    bit prev_ir;
    bit stale;
    logic [N*W-1:0] ra;
    logic [N*W-1:0] rb;

    vecs[0] = '{vec4(1, 2, 3, 4),         vec4(5, 6, 7, 8),         70,     "basic"};
    vecs[1] = '{vec4(-128, -128, -128, -128), vec4(-128, -128, -128, -128), 65536, "all_min"};
    vecs[2] = '{vec4(-128, -128, -128, -128), vec4(127, 127, 127, 127),  -65024, "min_max"};
    vecs[3] = '{vec4(-1, 2, -3, 4),       vec4(4, -3, 2, -1),       -20,    "mixed"};

    reset     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset res_valid", longint'(res_valid), 0);
    check("reset busy", longint'(busy), 0);
    check("reset result", longint'(result), 0);

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, vecs[i].name);
    end

    // Backpressure with in_valid pulses while the result waits.
    run_op(vec4(3, -7, 11, -13), vec4(-2, 5, 9, 4), -6 - 35 + 99 - 52, 6, 1'b1, "backpressure");

    // Randomized operations against the model.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 3)), 1'b1, "random");
    end

    // Reset during MAC cycle 2 aborts the operation.
    in_valid = 1'b1;
    a_in = vec4(10, 20, 30, 40);
    b_in = vec4(1, 1, 1, 1);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort in_ready", longint'(in_ready), 1);
    check("abort res_valid", longint'(res_valid), 0);
    check("abort busy", longint'(busy), 0);
    check("abort result", longint'(result), 0);
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) stale = 1'b1;
    end
    res_ready = 1'b0;
    check("abort no stale res_valid", longint'(stale), 0);
    run_op(vec4(-5, 6, -7, 8), vec4(9, -10, 11, -12), -45 - 60 - 77 - 96, 0, 1'b0, "after_abort");

    // Back-to-back with in_valid held high and res_ready tied high.
    pa[0] = vec4(1, 1, 1, 1);       pb[0] = vec4(2, 3, 4, 5);
    pa[1] = vec4(-9, 8, -7, 6);     pb[1] = vec4(5, 4, 3, 2);
    pa[2] = vec4(127, -128, 0, 50); pb[2] = vec4(127, 127, 99, -50);
    k = 0;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    a_in = pa[0];
    b_in = pb[0];
    for (cyc = 1; cyc <= 22; cyc++) begin
      prev_ir = in_ready;
      tick();
      if (prev_ir) begin
        k++;
        if (k < 3) begin
          a_in = pa[k];
          b_in = pb[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (res_valid) begin
        got_res.push_back(longint'(result));
        got_cyc.push_back(cyc);
      end
    end
    res_ready = 1'b0;
    check("b2b pulse count", got_res.size(), 3);
    if (got_res.size() == 3) begin
      check("b2b first latency", got_cyc[0], N + 1);
      check("b2b spacing 1", got_cyc[1] - got_cyc[0], N + 2);
      check("b2b spacing 2", got_cyc[2] - got_cyc[1], N + 2);
      for (int i = 0; i < 3; i++) begin
        check("b2b result", got_res[i], model(pa[i], pb[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
